// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry type for the instruction fetch front end
package fetch_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0;
    localparam int PC_STEP = 4;
    localparam int XLEN_DEF = 32;

    typedef struct packed {
        logic [INST_W-1:0]   inst;
        logic [XLEN_DEF-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry circular buffer of fetch entries, clear has priority
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  entry_t                 wdata,
    output logic [$clog2(DEPTH):0] count,
    output entry_t                 head
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[tail_q] <= wdata;
        end
    end

    assign head  = mem_q[head_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetching fetch unit feeding decode; FETCH_QUEUE_BYPASS_EN adds empty-queue bypass
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   d_ready,
    output logic                   d_valid,
    output logic [31:0]            d_inst,
    output logic [XLEN-1:0]        d_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;

    logic [CW-1:0]   fifo_count;
    entry_t          fifo_head;
    entry_t          push_entry;
    entry_t          head_entry;
    logic            resp_valid;
    logic            bypass;
    logic            pop;
    logic            fifo_push;
    logic            fifo_pop;
    logic            issue;
    logic [CW:0]     occupancy;

    assign resp_valid = inflight_q & ~redirect;
    assign push_entry = '{inst: imem_rdata, pc: req_pc_q + XLEN'(PC_STEP)};

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = resp_valid & (fifo_count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign head_entry = bypass ? push_entry : fifo_head;
    assign d_valid    = ((fifo_count != '0) | bypass) & ~redirect;
    assign d_inst     = d_valid ? head_entry.inst : NOP_INST;
    assign d_pc       = d_valid ? head_entry.pc : '0;
    assign pop        = d_valid & d_ready;

    // A bypassed response consumed by decode never touches storage.
    assign fifo_push  = resp_valid & ~(bypass & d_ready);
    assign fifo_pop   = pop & ~bypass;

    // Reserve a slot for the outstanding response so pushes never overflow.
    assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign issue      = rst & ~redirect & (occupancy < (CW+1)'(DEPTH));

    assign imem_req   = issue;
    assign imem_addr  = fetch_pc_q;
    assign count      = fifo_count;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            req_pc_d   = fetch_pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (redirect),
        .wdata (push_entry),
        .count (fifo_count),
        .head  (fifo_head)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue with a queue-based reference model
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int          LAT      = 2;
`else
    localparam int          LAT      = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        d_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        d_valid;
    logic [31:0] d_inst;
    logic [31:0] d_pc;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .d_ready     (d_ready),
        .d_valid     (d_valid),
        .d_inst      (d_inst),
        .d_pc        (d_pc),
        .count       (count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'h2000_0000 + (a >> 2);
    endfunction

    // Synchronous-read instruction memory; garbage when not requested.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? inst_of(imem_addr) : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] m_pc   = RESET_PC;
    logic [31:0] m_rpc  = '0;
    bit          m_infl = 1'b0;

    function automatic bit m_bypass();
`ifdef FETCH_QUEUE_BYPASS_EN
        return (mq.size() == 0) && m_infl && !redirect;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_valid();
        return ((mq.size() != 0) || m_bypass()) && !redirect;
    endfunction

    function automatic bit m_req();
        int occ;
        occ = mq.size() + int'(m_infl) - int'(m_valid() && d_ready);
        return rst && !redirect && (occ < DEPTH);
    endfunction

    function automatic ment_t m_head();
        ment_t e;
        e.inst = '0;
        e.pc   = '0;
        if (m_bypass()) begin
            e.inst = inst_of(m_rpc);
            e.pc   = m_rpc + 32'd4;
        end else if (mq.size() != 0) begin
            e = mq[0];
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_rpc  = '0;
            m_infl = 1'b0;
        end else begin
            bit    m_pop;
            bit    m_byp;
            bit    m_iss;
            ment_t e;
            m_byp  = m_bypass();
            m_pop  = m_valid() && d_ready;
            m_iss  = m_req();
            e.inst = inst_of(m_rpc);
            e.pc   = m_rpc + 32'd4;
            if (m_pop && !m_byp) void'(mq.pop_front());
            if (m_infl && !redirect && !(m_byp && d_ready)) mq.push_back(e);
            if (redirect) begin
                mq.delete();
                m_pc   = redirect_pc & ~32'h3;
                m_infl = 1'b0;
            end else if (m_iss) begin
                m_rpc  = m_pc;
                m_pc   = m_pc + 32'd4;
                m_infl = 1'b1;
            end else begin
                m_infl = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        ment_t h;
        bit    v;
        h = m_head();
        v = m_valid();
        chk("cmp_d_valid",   64'(d_valid),   64'(v));
        chk("cmp_count",     64'(count),     64'(mq.size()));
        chk("cmp_imem_req",  64'(imem_req),  64'(m_req()));
        chk("cmp_imem_addr", 64'(imem_addr), 64'(m_pc));
        chk("cmp_d_inst",    64'(d_inst),    64'(v ? h.inst : 32'h0));
        chk("cmp_d_pc",      64'(d_pc),      64'(v ? h.pc : 32'h0));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        bit  found;
        #2 rst = 1'b0;
        d_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_d_valid",  64'(d_valid),  64'(0));
        chk("rst_imem_req", 64'(imem_req), 64'(0));
        chk("rst_count",    64'(count),    64'(0));
        chk("rst_d_pc",     64'(d_pc),     64'(0));
        #1 rst = 1'b1;
        #1;
        chk("t1_req_on_release", 64'(imem_req),  64'(1));
        chk("t1_addr_reset_pc",  64'(imem_addr), 64'(RESET_PC));

        // Stream from reset with decode always ready.
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            if (k < LAT - 1) begin
                chk("t1_no_early_valid", 64'(d_valid), 64'(0));
            end else begin
                chk("t1_valid", 64'(d_valid), 64'(1));
                chk("t1_pc",    64'(d_pc),    64'(32'(4 * (k - LAT + 2))));
                chk("t1_inst",  64'(d_inst),  64'(32'h2000_0000 + 32'(k - LAT + 1)));
            end
        end

        // Stall decode: the queue fills to DEPTH and fetch stops.
        step();
        d_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_count_full", 64'(count),    64'(DEPTH));
        chk("t2_req_off",    64'(imem_req), 64'(0));
        chk("t2_head_pc",    64'(d_pc),     64'(32'd24));
        step();
        d_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("t2_resume_pc", 64'(d_pc), 64'(32'd24 + 32'(4 * j)));
        end

        // Misaligned redirect target is forced to a word boundary.
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        @(negedge clk);
        chk("t4_redir_d_valid",  64'(d_valid),  64'(0));
        chk("t4_redir_imem_req", 64'(imem_req), 64'(0));
        step();
        redirect = 1'b0;
        d_ready  = 1'b0;
        chk("t4_aligned_addr", 64'(imem_addr), 64'(32'h40));
        chk("t4_count_clear",  64'(count),     64'(0));

        // Fill to DEPTH-1 with a request outstanding, then redirect.
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mq.size() == DEPTH - 1 && m_infl) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("t3_setup_inflight", 64'(found), 64'(1));
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        chk("t3_redir_d_valid", 64'(d_valid), 64'(0));
        chk("t3_redir_req",     64'(imem_req), 64'(0));
        step();
        redirect = 1'b0;
        d_ready  = 1'b1;
        chk("t3_count_zero", 64'(count),     64'(0));
        chk("t3_addr",       64'(imem_addr), 64'(32'h40));
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (d_valid) break;
        end
        chk("t3_latency", 64'(n),      64'(LAT));
        chk("t3_pc",      64'(d_pc),   64'(32'h44));
        chk("t3_inst",    64'(d_inst), 64'(32'h2000_0010));

        // Fetch PC wraps modulo 2^32.
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("t4_wrap_top", 64'(imem_addr), 64'(32'hFFFF_FFFC));
        step();
        chk("t4_wrap_zero", 64'(imem_addr), 64'(32'h0));

        // Asynchronous reset mid-cycle while streaming; stale response must vanish.
        repeat (4) @(negedge clk);
        chk("t5_pre_valid", 64'(d_valid), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("t5_async_d_valid",  64'(d_valid),  64'(0));
        chk("t5_async_count",    64'(count),    64'(0));
        chk("t5_async_imem_req", 64'(imem_req), 64'(0));
        #1 rst = 1'b1;
        #1;
        chk("t5_restart_addr", 64'(imem_addr), 64'(RESET_PC));
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (d_valid) break;
        end
        chk("t5_latency", 64'(n),      64'(LAT - 1));
        chk("t5_pc",      64'(d_pc),   64'(32'h4));
        chk("t5_inst",    64'(d_inst), 64'(32'h2000_0000));

`ifdef FETCH_QUEUE_BYPASS_EN
        // With bypass, a ready decode sees the target two cycles after redirect.
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d_valid) break;
            n++;
        end
        chk("t6_latency", 64'(n),    64'(2));
        chk("t6_pc",      64'(d_pc), 64'(32'h84));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_count_zero", 64'(count), 64'(0));
        end
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
